// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 keypad scanner: FSM state encoding, row and
// column index widths, and helpers for key-code encoding and row decoding.
// Optional feature macro used by the scanner: KEYPAD_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int ROW_W    = 2;
    localparam int COL_W    = 2;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = ROW_W + COL_W;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } kp_state_t;

    // key_code = row*4 + col, which is just the concatenation of the indices
    function automatic logic [CODE_W-1:0] key_encode(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        return {row, col};
    endfunction

    // True when exactly one active-low row is pulled down
    function automatic logic single_low(input logic [NUM_ROWS-1:0] rows_n);
        logic [NUM_ROWS-1:0] low;
        low = ~rows_n;
        return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    endfunction

    // Index of the low row; only meaningful when single_low() is true
    function automatic logic [ROW_W-1:0] low_row_idx(input logic [NUM_ROWS-1:0] rows_n);
        logic [ROW_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows_n[i]) begin
                idx = ROW_W'(i);
            end
        end
        return idx;
    endfunction

    // One-cold, active-low column drive
    function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] col_idx);
        return ~(4'b0001 << col_idx);
    endfunction

endpackage

// File: rtl/key_debounce_timer.sv
// -----------------------------------------------------------------------------
// key_debounce_timer
// Stability counter for press/release debounce. Counts enabled cycles after a
// clear and saturates at CNT-1, so it never wraps while a level stays stable.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-low
//   i_clear  in   restart the count (has priority over i_enable)
//   i_enable in   count this cycle
//   o_done   out  counter sits at terminal count (CNT-1); the enabled cycle
//                 seen with o_done high is the CNT-th stable cycle
// -----------------------------------------------------------------------------
module key_debounce_timer
    import keypad_pkg::*;
#(
    parameter int CNT = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_done
);

    localparam int            CW = (CNT > 1) ? $clog2(CNT) : 1;
    localparam logic [CW-1:0] TC = CW'(CNT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != TC)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_done = (r_cnt == TC);

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner with press/release debounce and optional idle
// timeout. Columns are driven one-cold; rows are sampled in the last cycle of
// each column dwell. A single low row starts press debounce on that key.
//
// Optional feature: define KEYPAD_TIMEOUT_EN to build the idle-timeout counter
// behind time_max_id; otherwise time_max_id is tied low.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-low
//   row_in[3:0]  in   keypad rows, active-low
//   col_out[3:0] out  column drive, one-cold active-low
//   apt          out  debounced key-held level
//   key_code[3:0]out  last accepted key, row*4+col
//   key_valid    out  one-cycle pulse per accepted press
//   time_max_id  out  one-cycle idle-timeout pulse
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_SCAN       | rotating columns, sampling rows at end of each dwell
// ST_PRESS_DB   | column frozen, waiting for latched row to stay low
// ST_HELD       | key accepted, column frozen until latched row goes high
// ST_RELEASE_DB | column frozen, waiting for latched row to stay high
// -----------------------------------------------------------------------------
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_CNT   = 500000,
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       apt,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       time_max_id
);

    localparam int               DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);

    kp_state_t         r_state;
    logic [COL_W-1:0]  r_col_idx;
    logic [ROW_W-1:0]  r_row_idx;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid;

    kp_state_t         w_state_nxt;
    logic [COL_W-1:0]  w_col_nxt;
    logic [ROW_W-1:0]  w_row_nxt;
    logic [DIV_W-1:0]  w_div_nxt;
    logic              w_db_clear;
    logic              w_db_enable;
    logic              w_db_done;
    logic              w_accept;
    logic              w_row_lvl;

    // Level of the latched row; 1 means the key is open
    assign w_row_lvl = row_in[r_row_idx];

    key_debounce_timer #(
        .CNT (DEBOUNCE_CNT)
    ) u_db_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_db_clear),
        .i_enable (w_db_enable),
        .o_done   (w_db_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_SCAN;
            r_col_idx   <= '0;
            r_row_idx   <= '0;
            r_div_cnt   <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col_idx   <= w_col_nxt;
            r_row_idx   <= w_row_nxt;
            r_div_cnt   <= w_div_nxt;
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= key_encode(r_row_idx, r_col_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col_idx;
        w_row_nxt   = r_row_idx;
        w_div_nxt   = r_div_cnt;
        w_db_clear  = 1'b0;
        w_db_enable = 1'b0;
        w_accept    = 1'b0;

        case (r_state)
            ST_SCAN: begin
                if (r_div_cnt == DIV_TC) begin
                    // Dwell counter restarts either way, so a later return to
                    // scanning always begins with a full dwell.
                    w_div_nxt = '0;
                    if (single_low(row_in)) begin
                        w_row_nxt   = low_row_idx(row_in);
                        w_db_clear  = 1'b1;
                        w_state_nxt = ST_PRESS_DB;
                    end else begin
                        w_col_nxt = r_col_idx + COL_W'(1);
                    end
                end else begin
                    w_div_nxt = r_div_cnt + DIV_W'(1);
                end
            end

            ST_PRESS_DB: begin
                if (w_row_lvl) begin
                    w_col_nxt   = r_col_idx + COL_W'(1);
                    w_state_nxt = ST_SCAN;
                end else begin
                    w_db_enable = 1'b1;
                    if (w_db_done) begin
                        w_accept    = 1'b1;
                        w_state_nxt = ST_HELD;
                    end
                end
            end

            ST_HELD: begin
                if (w_row_lvl) begin
                    w_db_clear  = 1'b1;
                    w_state_nxt = ST_RELEASE_DB;
                end
            end

            ST_RELEASE_DB: begin
                if (!w_row_lvl) begin
                    w_state_nxt = ST_HELD;
                end else begin
                    w_db_enable = 1'b1;
                    if (w_db_done) begin
                        w_col_nxt   = r_col_idx + COL_W'(1);
                        w_state_nxt = ST_SCAN;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

`ifdef KEYPAD_TIMEOUT_EN
    localparam int              TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_TC = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_to_armed;
    logic            r_time_max;

    // Only idle scanning time counts; the counter stays disarmed until the
    // first accepted key so a keypad nobody touched never times out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt   <= '0;
            r_to_armed <= 1'b0;
            r_time_max <= 1'b0;
        end else begin
            r_time_max <= 1'b0;
            if (w_accept) begin
                r_to_armed <= 1'b1;
                r_to_cnt   <= '0;
            end else if (r_to_armed && (r_state == ST_SCAN)) begin
                if (r_to_cnt == TO_TC) begin
                    r_time_max <= 1'b1;
                    r_to_armed <= 1'b0;
                    r_to_cnt   <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
            end
        end
    end

    assign time_max_id = r_time_max;
`else
    assign time_max_id = 1'b0;
`endif

    assign col_out   = col_drive(r_col_idx);
    assign apt       = (r_state == ST_HELD) || (r_state == ST_RELEASE_DB);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=8, TIMEOUT_CYCLES=100.
// A contact map (which keys are physically closed at each cycle) drives a
// simulated keypad matrix; a timeline model derives the expected outputs.
module tb_keypad_scan;

    localparam int SD   = 4;
    localparam int DB   = 8;
    localparam int TO   = 100;
    localparam int MAXH = 1000;
`ifdef KEYPAD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       apt;
    logic [3:0] key_code;
    logic       key_valid;
    logic       time_max_id;

    always #5 clk = ~clk;

    keypad_scan #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_CNT   (DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .apt         (apt),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .time_max_id (time_max_id)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int horizon  = 0;
    int kv_seen;
    int kv_model;
    int first_kv_code;

    logic [15:0] contact   [MAXH];
    int          exp_col   [MAXH];
    bit          exp_apt   [MAXH];
    bit          exp_kv    [MAXH];
    int          exp_kvcode[MAXH];
    bit          exp_scan  [MAXH];
    bit          exp_to    [MAXH];
    int          exp_code  [MAXH];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic bit pressed(input int t, input int r, input int c);
        return contact[t][r*4+c];
    endfunction

    function automatic int rows_closed(input int t, input int c);
        int n;
        n = 0;
        for (int r = 0; r < 4; r++) if (contact[t][r*4+c]) n++;
        return n;
    endfunction

    function automatic int closed_row(input int t, input int c);
        int idx;
        idx = 0;
        for (int r = 0; r < 4; r++) if (contact[t][r*4+c]) idx = r;
        return idx;
    endfunction

    task automatic clear_plan();
        for (int t = 0; t < MAXH; t++) contact[t] = 16'h0;
    endtask

    task automatic press(input int key, input int t0, input int t1);
        for (int i = t0; i < t1 && i < MAXH; i++) contact[i][key] = 1'b1;
    endtask

    // Walks the contact timeline: scanning columns advance every SD cycles from
    // a base point; a lone closed key seen at a dwell end must stay closed DB
    // more cycles to be accepted; an accepted key must stay open DB cycles to
    // be released. Scanning restarts at the following column after either exit.
    task automatic build_model();
        int t, base, bcol, c, r, k, n, h, m, nr, cur, cnt;
        bit ok, done, back, armed;
        for (int i = 0; i < MAXH; i++) begin
            exp_col[i] = 0; exp_apt[i] = 0; exp_kv[i] = 0; exp_kvcode[i] = 0;
            exp_scan[i] = 0; exp_to[i] = 0; exp_code[i] = 0;
        end
        t = 0; base = 0; bcol = 0;
        while (t < horizon) begin
            c = (bcol + (t - base) / SD) % 4;
            exp_col[t]  = c;
            exp_scan[t] = 1;
            if (((t - base) % SD == SD - 1) && (rows_closed(t, c) == 1)) begin
                r = closed_row(t, c);
                k = t + 1; n = 0; ok = 0;
                while (k < horizon) begin
                    exp_col[k] = c;
                    if (!pressed(k, r, c)) break;
                    n++;
                    if (n == DB) begin ok = 1; break; end
                    k++;
                end
                if (!ok) begin
                    base = k + 1; bcol = (c + 1) % 4; t = k + 1;
                end else begin
                    h = k + 1; done = 0;
                    if (h < horizon) begin exp_kv[h] = 1; exp_kvcode[h] = r*4 + c; end
                    while (h < horizon && !done) begin
                        exp_col[h] = c; exp_apt[h] = 1;
                        if (pressed(h, r, c)) begin
                            h++;
                        end else begin
                            m = h + 1; nr = 0; back = 0;
                            while (m < horizon) begin
                                exp_col[m] = c; exp_apt[m] = 1;
                                if (pressed(m, r, c)) begin back = 1; break; end
                                nr++;
                                if (nr == DB) break;
                                m++;
                            end
                            if (back) h = m + 1;
                            else begin done = 1; base = m + 1; bcol = (c + 1) % 4; t = m + 1; end
                        end
                    end
                    if (!done) t = horizon;
                end
            end else begin
                t++;
            end
        end
        cur = 0; kv_model = 0; armed = 0; cnt = 0;
        for (int i = 0; i < horizon; i++) begin
            if (exp_kv[i]) begin cur = exp_kvcode[i]; kv_model++; end
            exp_code[i] = cur;
            if (exp_kv[i]) begin
                armed = 1; cnt = 0;
            end else if (armed && exp_scan[i]) begin
                cnt++;
                if (cnt == TO) begin
                    if (i + 1 < horizon) exp_to[i+1] = TO_EN;
                    armed = 0; cnt = 0;
                end
            end
        end
    endtask

    task automatic drive_rows(input int t);
        logic [3:0] rows;
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (contact[t][r*4+c] && !col_out[c]) rows[r] = 1'b0;
        row_in = rows;
    endtask

    task automatic check_cycle(input int t);
        logic [3:0] ec;
        ec = ~(4'b0001 << exp_col[t]);
        check_eq("col_out", col_out, ec);
        check_eq("apt", apt, exp_apt[t]);
        check_eq("key_valid", key_valid, exp_kv[t]);
        check_eq("key_code", key_code, exp_code[t]);
        check_eq("time_max_id", time_max_id, exp_to[t]);
    endtask

    // Reset for one edge (with whatever rows were last driven), then run the
    // planned timeline for h cycles comparing every cycle.
    task automatic run_epoch(input int h);
        horizon = h;
        build_model();
        kv_seen = 0;
        first_kv_code = 255;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int t = 0; t < horizon; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            cyc = t;
            drive_rows(t);
            check_cycle(t);
            if (key_valid === 1'b1) begin
                kv_seen++;
                if (first_kv_code == 255) first_kv_code = int'(key_code);
            end
        end
        check_eq("kv_count", kv_seen, kv_model);
    endtask

    task automatic plan_random();
        int t, key, dur, sty, k2;
        clear_plan();
        t = $urandom_range(5, 30);
        while (t < 400) begin
            key = $urandom_range(0, 15);
            dur = $urandom_range(1, 45);
            sty = $urandom_range(0, 5);
            if (sty == 0) begin
                for (int i = 0; i < dur; i++) if (i % 4 != 3) contact[t+i][key] = 1'b1;
            end else begin
                press(key, t, t + dur);
                if (sty == 1) begin
                    k2 = ((key / 4 + 1 + $urandom_range(0, 2)) % 4) * 4 + key % 4;
                    press(k2, t, t + dur);
                end
            end
            t += dur + $urandom_range(25, 50);
        end
    endtask

    initial begin
        int st, dur, key, hkv;
        rst    = 1'b0;
        row_in = 4'hF;
        repeat (3) @(posedge clk);
        #1;

        // Directed: idle scan, key (2,1), bounce, two rows, then random keys
        // and a long idle tail for the timeout.
        clear_plan();
        press(9, 20, 61);
        for (int t = 100; t < 140; t++) if ((t - 100) % 4 != 3) contact[t][7] = 1'b1;
        press(7, 140, 200);
        press(2, 230, 290);
        press(14, 230, 290);
        for (int i = 0; i < 4; i++) begin
            key = $urandom_range(0, 15);
            st  = 310 + i * 60;
            dur = $urandom_range(2, 30);
            press(key, st, st + dur);
        end
        run_epoch(700);
        check_eq("first_code_9", first_kv_code, 9);

        for (int e = 0; e < 3; e++) begin
            plan_random();
            run_epoch(600);
        end

        // Key held across a reset edge: run until a few cycles into HELD.
        clear_plan();
        press(0, 0, MAXH);
        horizon = MAXH;
        build_model();
        hkv = MAXH - 6;
        for (int i = MAXH - 1; i >= 0; i--) if (exp_kv[i]) hkv = i;
        run_epoch(hkv + 5);

        // Reset lands while the key is still held; keypad then idle.
        clear_plan();
        run_epoch(40);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each column is driven (dwell).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 500000, clock cycles a row level must be stable to be accepted.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250000000, idle clock cycles before time_max_id fires.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port row_in  input  4  keypad rows, active-low (pulled up); row_in[r]=0 means row r shorted to the driven column.
REQ-007 SHALL have port col_out  output  4  column drive, one-cold, active-low.
REQ-008 SHALL have port apt  output  1  debounced "key held" level, consumed by the ID-entry FSM.
REQ-009 SHALL have port key_code  output  4  code of the last accepted key, row*4+col.
REQ-010 SHALL have port key_valid  output  1  one-cycle pulse on each accepted press.
REQ-011 SHALL have port time_max_id  output  1  one-cycle idle-timeout pulse.

Function
REQ-012 SHALL implement states SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-013 SCAN: SHALL drive col_out=~(4'b0001<<col_idx); col_idx SHALL advance every SCAN_DIV cycles and wrap 3->0.
REQ-014 SCAN: SHALL sample row_in only in the last dwell cycle; exactly one row low SHALL latch row_idx/col_idx, freeze the column, clear the debounce counter and enter PRESS_DB.
REQ-015 SCAN: zero or multiple rows low SHALL be treated as no key; scanning continues.
REQ-016 PRESS_DB: latched row high on any cycle SHALL return to SCAN, resuming at the next column.
REQ-017 PRESS_DB: row low for DEBOUNCE_CNT consecutive cycles SHALL enter HELD; apt SHALL rise, key_valid SHALL pulse, key_code SHALL update, all on the same edge.
REQ-018 HELD: column SHALL stay frozen; latched row high SHALL enter RELEASE_DB with a cleared counter.
REQ-019 RELEASE_DB: row low again SHALL return to HELD without a new key_valid.
REQ-020 RELEASE_DB: row high for DEBOUNCE_CNT consecutive cycles SHALL enter SCAN and drop apt on the same edge.
REQ-021 apt SHALL be 1 exactly in HELD and RELEASE_DB.
REQ-022 key_code SHALL hold its value until the next accepted press.
REQ-023 Counter widths SHALL be $clog2 of their parameter and SHALL not overflow at terminal count.

Reset
REQ-024 rst=0 at a clock edge SHALL force state SCAN, col_idx=0, col_out=4'b1110, apt=0, key_valid=0, key_code=0, time_max_id=0, all counters 0.
REQ-025 Reset mid-press, in any state, SHALL take effect on that edge and SHALL generate no key_valid.

Configuration
REQ-026 With KEYPAD_TIMEOUT_EN defined: the timeout counter SHALL arm on the first key_valid after reset, count cycles in SCAN, and clear on each key_valid.
REQ-027 With KEYPAD_TIMEOUT_EN defined: reaching TIMEOUT_CYCLES SHALL pulse time_max_id for one cycle and disarm the counter.
REQ-028 Without KEYPAD_TIMEOUT_EN: time_max_id SHALL be constant 0 and no timeout counter SHALL be synthesized.

Structure
REQ-029 Shared package keypad_pkg SHALL hold the state encoding, ROW_W/COL_W=2 and the key_code encoding function.
REQ-030 The press/release stability counter SHALL be sub-module key_debounce_timer (clear, enable, done at terminal count).

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, TIMEOUT_CYCLES=100)
REQ-031 Idle rows 4'b1111 -> col_out cycles 1110,1101,1011,0111,1110 every 4 clocks; apt=0.
REQ-032 row_in[2]=0 held while column 1 is driven -> after 8 stable cycles key_valid single pulse, key_code=9, apt=1; release for 8 cycles -> apt=0, scanning resumes.
REQ-033 Bounce: row low 3 cycles, high 1, then low -> no key_valid until 8 consecutive low cycles; exactly one pulse total.
REQ-034 Two rows low simultaneously -> no PRESS_DB entry, no key_valid, scanning continues.
REQ-035 rst=0 for one edge while in HELD -> apt=0 and col_out=1110 on that edge, no key_valid.
REQ-036 KEYPAD_TIMEOUT_EN defined: one press and release then 100 idle SCAN cycles -> single time_max_id pulse, none further; undefined -> time_max_id stays 0.
